// File: rtl/sync_event_counter.sv
// Single-clock event counter: registers NUM_SRC event inputs, selects one with a data mux,
// and counts its rising edges with up/down, wrap/saturate, load and a sticky overflow flag.
module sync_event_counter #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    input  logic [NUM_SRC-1:0] di,
    input  logic               dir,
    input  logic               sat_mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               clr_ovf,
    output logic [WIDTH-1:0]   count,
    output logic               evt,
    output logic               tc,
    output logic               ovf
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [NUM_SRC-1:0] di_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_prev;
    logic               s;
    logic               s_prev;
    logic               raw_evt;
    logic               cnt_evt;
    logic               at_limit;
    logic [WIDTH-1:0]   count_nxt;

    // Out-of-range selects read as a constant low source, so they never produce events.
    always_comb begin
        s = 1'b0;
        if (int'(sel_q) < NUM_SRC) begin
            s = di_q[sel_q];
        end
    end

    // A select change masks the edge detector for one cycle so switching never fakes an edge.
    assign raw_evt = s & ~s_prev & (sel_q == sel_prev);
    assign cnt_evt = raw_evt & en & ~load;

    assign at_limit = dir ? (count == MAX) : (count == '0);

    always_comb begin
        count_nxt = count;
        if (dir) begin
            if (!at_limit)     count_nxt = count + WIDTH'(1);
            else if (sat_mode) count_nxt = MAX;
            else               count_nxt = '0;
        end else begin
            if (!at_limit)     count_nxt = count - WIDTH'(1);
            else if (sat_mode) count_nxt = '0;
            else               count_nxt = MAX;
        end
    end

    assign tc = at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            di_q     <= '0;
            sel_q    <= '0;
            sel_prev <= '0;
            s_prev   <= 1'b0;
            count    <= '0;
            evt      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            di_q     <= di;
            sel_q    <= sel;
            sel_prev <= sel_q;
            s_prev   <= s;
            if (load) begin
                count <= load_val;
                evt   <= 1'b0;
            end else begin
                evt <= cnt_evt;
                if (cnt_evt) begin
                    count <= count_nxt;
                end
                // A new overflow beats a coincident clear.
                if (cnt_evt && at_limit) begin
                    ovf <= 1'b1;
                end else if (clr_ovf) begin
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_event_counter.sv
// Directed bench for sync_event_counter (WIDTH=4, NUM_SRC=2) with hand-computed expectations.
module tb_sync_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [0:0] sel;
    logic [1:0] di;
    logic       dir;
    logic       sat_mode;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;
    logic [3:0] count;
    logic       evt;
    logic       tc;
    logic       ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    sync_event_counter #(.WIDTH(4), .NUM_SRC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sel      (sel),
        .di       (di),
        .dir      (dir),
        .sat_mode (sat_mode),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .evt      (evt),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the masked di bits for one sampled edge then drop them; the count
    // reflects the edge right after the second tick.
    task automatic pulse(input logic [1:0] mask);
        di = di | mask;
        tick();
        di = di & ~mask;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sel = 1'b0; di = 2'b00; dir = 1'b1;
        sat_mode = 1'b0; load = 1'b0; load_val = 4'h0; clr_ovf = 1'b0;

        // Reset and latency
        tick(); tick();
        rst = 1'b0;
        check("rst_count", count, 4'h0);
        check("rst_evt", evt, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_tc_up", tc, 1'b0);
        dir = 1'b0; #1;
        check("rst_tc_down", tc, 1'b1);
        dir = 1'b1;
        di[0] = 1'b1;
        tick();
        check("lat_count_N", count, 4'h0);
        check("lat_evt_N", evt, 1'b0);
        di[0] = 1'b0;
        tick();
        check("lat_count_N1", count, 4'h1);
        check("lat_evt_N1", evt, 1'b1);
        tick();
        check("lat_evt_N2", evt, 1'b0);
        check("lat_ovf", ovf, 1'b0);

        // Wrap
        load_val = 4'hE; load = 1'b1;
        tick();
        load = 1'b0;
        check("wrap_load", count, 4'hE);
        check("wrap_tc_E", tc, 1'b0);
        pulse(2'b01);
        check("wrap_F", count, 4'hF);
        check("wrap_tc_F", tc, 1'b1);
        check("wrap_ovf_F", ovf, 1'b0);
        pulse(2'b01);
        check("wrap_0", count, 4'h0);
        check("wrap_ovf_0", ovf, 1'b1);
        check("wrap_tc_0", tc, 1'b0);
        pulse(2'b01);
        check("wrap_1", count, 4'h1);
        check("wrap_tc_1", tc, 1'b0);

        // Saturate down and overflow clear
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("sat_pre_clr", ovf, 1'b0);
        dir = 1'b0; sat_mode = 1'b1;
        pulse(2'b01);
        check("sat_c1", count, 4'h0);
        check("sat_e1", evt, 1'b1);
        check("sat_o1", ovf, 1'b0);
        pulse(2'b01);
        check("sat_c2", count, 4'h0);
        check("sat_e2", evt, 1'b1);
        check("sat_o2", ovf, 1'b1);
        pulse(2'b01);
        check("sat_c3", count, 4'h0);
        check("sat_e3", evt, 1'b1);
        check("sat_tc", tc, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", ovf, 1'b0);
        di[0] = 1'b1;
        tick();
        di[0] = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_vs_set", ovf, 1'b1);
        check("clr_vs_set_evt", evt, 1'b1);

        // Source switch
        dir = 1'b1; sat_mode = 1'b0;
        di = 2'b10;
        tick(); tick();
        check("sw_sel0_steady", count, 4'h0);
        sel = 1'b1;
        tick();
        check("sw_evt_a", evt, 1'b0);
        tick();
        check("sw_evt_b", evt, 1'b0);
        check("sw_count", count, 4'h0);
        tick();
        check("sw_count2", count, 4'h0);
        di = 2'b00;
        tick(); tick();
        pulse(2'b11);
        check("sw_c1", count, 4'h1);
        pulse(2'b11);
        check("sw_c2", count, 4'h2);
        pulse(2'b01);
        check("sw_ign_c", count, 4'h2);
        check("sw_ign_e", evt, 1'b0);

        // Priority and enable
        load_val = 4'h5;
        di[1] = 1'b1;
        tick();
        load = 1'b1; di[1] = 1'b0;
        tick();
        load = 1'b0;
        check("pri_load_c", count, 4'h5);
        check("pri_load_e", evt, 1'b0);
        check("pri_load_ovf", ovf, 1'b1);
        tick();
        check("pri_drop_c", count, 4'h5);
        en = 1'b0;
        pulse(2'b10);
        check("en_c", count, 4'h5);
        check("en_e", evt, 1'b0);
        en = 1'b1;
        di[1] = 1'b1;
        tick();
        rst = 1'b1; di[1] = 1'b0;
        tick();
        rst = 1'b0;
        check("pri_rst_c", count, 4'h0);
        check("pri_rst_e", evt, 1'b0);
        check("pri_rst_o", ovf, 1'b0);
        tick(); tick();
        check("pri_rst_lost_c", count, 4'h0);
        check("pri_rst_lost_e", evt, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
